// File: rtl/uart_pkg.sv
// Shared UART types and framing constants for the bench-side transceiver.
// No logic; imported by the timer and the TX/RX top.
package uart_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } uart_state_e;

  // start + 8 data + stop
  localparam int FRAME_BITS = 10;

endpackage

// File: rtl/uart_bit_timer.sv
// Bit-period counter: half_tick at mid-bit, full_tick on the last cycle of a bit.
// Zero latency (ticks are decoded from the count); restart or full_tick clears the count.
module uart_bit_timer #(
  parameter int CLKS_PER_BIT = 4167
) (
  input  logic clock,
  input  logic resetb,
  input  logic restart,
  output logic half_tick,
  output logic full_tick
);

  localparam int CW = $clog2(CLKS_PER_BIT) + 1;
  localparam logic [CW-1:0] HALF_CNT = CW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CW-1:0] FULL_CNT = CW'(CLKS_PER_BIT - 1);

  logic [CW-1:0] cnt;

  always_ff @(posedge clock or negedge resetb) begin
    if (!resetb) begin
      cnt <= '0;
    end else if (restart || full_tick) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + CW'(1);
    end
  end

  assign half_tick = (cnt == HALF_CNT);
  assign full_tick = (cnt == FULL_CNT);

endmodule

// File: rtl/uart_tb_txrx.sv
// Bench-side 8N1 UART transceiver; TX launches one clock after a tx_start rising edge.
// No backpressure: tx_start edges while busy are dropped, RX bytes are pulsed out and not held.
module uart_tb_txrx
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = 4167,
  parameter int DATA_BITS    = 8
) (
  input  logic       clock,
  input  logic       resetb,
  input  logic       ser_rx,
  output logic       ser_tx,
  input  logic       tx_start,
  input  logic [7:0] tx_data,
  output logic       tx_busy,
  output logic       tx_clear_req,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  output logic       rx_frame_err
);

  localparam logic [2:0] LAST_BIT = 3'(DATA_BITS - 1);

  // ---------------------------------------------------------------- TX path
  uart_state_e tx_state, tx_state_nxt;
  logic        tx_start_q;
  logic [7:0]  tx_shreg;
  logic [2:0]  tx_idx;
  logic        tx_launch, tx_done, tx_restart;
  logic        tx_full, tx_half_unused;

  uart_bit_timer #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_tx_timer (
    .clock     (clock),
    .resetb    (resetb),
    .restart   (tx_restart),
    .half_tick (tx_half_unused),
    .full_tick (tx_full)
  );

  always_ff @(posedge clock or negedge resetb) begin
    if (!resetb) tx_state <= IDLE;
    else         tx_state <= tx_state_nxt;
  end

  always_comb begin
    tx_state_nxt = tx_state;
    tx_launch    = 1'b0;
    tx_done      = 1'b0;
    case (tx_state)
      IDLE: begin
        if (tx_start && !tx_start_q) begin
          tx_launch    = 1'b1;
          tx_state_nxt = START;
        end
      end
      START: if (tx_full) tx_state_nxt = DATA;
      DATA:  if (tx_full && tx_idx == LAST_BIT) tx_state_nxt = STOP;
      STOP: begin
        if (tx_full) begin
          tx_done      = 1'b1;
          tx_state_nxt = IDLE;
        end
      end
      default: tx_state_nxt = IDLE;
    endcase
    // Holding the timer cleared in IDLE makes START last exactly one bit period.
    tx_restart = (tx_state == IDLE) || (tx_state_nxt != tx_state);
  end

  always_ff @(posedge clock or negedge resetb) begin
    if (!resetb) begin
      tx_start_q   <= 1'b0;
      tx_shreg     <= '0;
      tx_idx       <= '0;
      tx_busy      <= 1'b0;
      tx_clear_req <= 1'b0;
    end else begin
      tx_start_q   <= tx_start;
      tx_clear_req <= tx_done;
      if (tx_launch) begin
        tx_shreg <= tx_data;
        tx_idx   <= '0;
        tx_busy  <= 1'b1;
      end else if (tx_state == DATA && tx_full) begin
        tx_shreg <= {1'b0, tx_shreg[7:1]};
        if (tx_idx != LAST_BIT) tx_idx <= tx_idx + 3'd1;
      end
      if (tx_done) tx_busy <= 1'b0;
    end
  end

  always_comb begin
    case (tx_state)
      START:   ser_tx = 1'b0;
      DATA:    ser_tx = tx_shreg[0];
      default: ser_tx = 1'b1;
    endcase
  end

  // ---------------------------------------------------------------- RX path
  uart_state_e rx_state, rx_state_nxt;
  logic [1:0]  rx_sync;
  logic        rx_s;
  logic [7:0]  rx_shreg;
  logic [2:0]  rx_idx;
  logic        rx_shift, rx_good, rx_bad, rx_restart;
  logic        rx_half, rx_full;

  uart_bit_timer #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_rx_timer (
    .clock     (clock),
    .resetb    (resetb),
    .restart   (rx_restart),
    .half_tick (rx_half),
    .full_tick (rx_full)
  );

  // Synchroniser resets to the idle level so reset release cannot fake a start bit.
  always_ff @(posedge clock or negedge resetb) begin
    if (!resetb) rx_sync <= 2'b11;
    else         rx_sync <= {rx_sync[0], ser_rx};
  end
  assign rx_s = rx_sync[1];

  always_ff @(posedge clock or negedge resetb) begin
    if (!resetb) rx_state <= IDLE;
    else         rx_state <= rx_state_nxt;
  end

  always_comb begin
    rx_state_nxt = rx_state;
    rx_shift     = 1'b0;
    rx_good      = 1'b0;
    rx_bad       = 1'b0;
    case (rx_state)
      IDLE:  if (!rx_s) rx_state_nxt = START;
      START: if (rx_half) rx_state_nxt = rx_s ? IDLE : DATA;
      DATA: begin
        if (rx_full) begin
          rx_shift = 1'b1;
          if (rx_idx == LAST_BIT) rx_state_nxt = STOP;
        end
      end
      STOP: begin
        if (rx_full) begin
          rx_good      = rx_s;
          rx_bad       = !rx_s;
          rx_state_nxt = IDLE;
        end
      end
      default: rx_state_nxt = IDLE;
    endcase
    // Restarting on the mid-start check puts every later full_tick at mid-bit.
    rx_restart = (rx_state == IDLE) || (rx_state_nxt != rx_state);
  end

  always_ff @(posedge clock or negedge resetb) begin
    if (!resetb) begin
      rx_shreg     <= '0;
      rx_idx       <= '0;
      rx_data      <= '0;
      rx_valid     <= 1'b0;
      rx_frame_err <= 1'b0;
    end else begin
      rx_valid     <= rx_good;
      rx_frame_err <= rx_bad;
      if (rx_state == START) rx_idx <= '0;
      if (rx_shift) begin
        rx_shreg <= {rx_s, rx_shreg[7:1]};
        if (rx_idx != LAST_BIT) rx_idx <= rx_idx + 3'd1;
      end
      if (rx_good) rx_data <= rx_shreg;
    end
  end

endmodule

// File: tb/tb_uart_tb_txrx.sv
// Directed bench for uart_tb_txrx at 8 clocks per bit: reset, TX framing, RX framing,
// glitch rejection, frame errors and full duplex, all against hand-computed bit patterns.
module tb_uart_tb_txrx;
  import uart_pkg::*;

  localparam int CPB = 8;

  logic       clock = 1'b0;
  logic       resetb;
  logic       ser_rx;
  logic       ser_tx;
  logic       tx_start;
  logic [7:0] tx_data;
  logic       tx_busy;
  logic       tx_clear_req;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       rx_frame_err;

  int checks = 0;
  int errors = 0;

  logic [7:0] rx_q[$];
  int         err_cnt = 0;

  uart_tb_txrx #(.CLKS_PER_BIT(CPB), .DATA_BITS(8)) dut (
    .clock        (clock),
    .resetb       (resetb),
    .ser_rx       (ser_rx),
    .ser_tx       (ser_tx),
    .tx_start     (tx_start),
    .tx_data      (tx_data),
    .tx_busy      (tx_busy),
    .tx_clear_req (tx_clear_req),
    .rx_data      (rx_data),
    .rx_valid     (rx_valid),
    .rx_frame_err (rx_frame_err)
  );

  always #5 clock = ~clock;

  always @(negedge clock) begin
    if (resetb && rx_valid) rx_q.push_back(rx_data);
    if (resetb && rx_frame_err) err_cnt++;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Called on the negedge where tx_start was raised; the following posedge launches.
  task automatic tx_frame(input logic [9:0] exp, input bit poke, input string tag);
    int match;
    int busy_cnt = 0;
    int clr_cnt  = 0;
    int late_busy = 0;
    @(negedge clock);
    check({tag, " busy_rise"}, tx_busy, 1);
    for (int b = 0; b < FRAME_BITS; b++) begin
      match = 0;
      for (int c = 0; c < CPB; c++) begin
        if (ser_tx === exp[b]) match++;
        if (tx_busy) busy_cnt++;
        if (tx_clear_req) clr_cnt++;
        if (poke && b == 4 && c == 0) tx_start = 1'b0;
        if (poke && b == 4 && c == 1) begin
          tx_start = 1'b1;
          tx_data  = 8'hFF;
        end
        @(negedge clock);
      end
      check($sformatf("%s bit%0d", tag, b), match, CPB);
    end
    check({tag, " busy_in_frame"}, busy_cnt, FRAME_BITS * CPB);
    check({tag, " clr_in_frame"}, clr_cnt, 0);
    check({tag, " clr_pulse"}, tx_clear_req, 1);
    check({tag, " busy_fall"}, tx_busy, 0);
    @(negedge clock);
    check({tag, " clr_once"}, tx_clear_req, 0);
    repeat (2 * CPB) begin
      if (tx_busy || !ser_tx) late_busy++;
      @(negedge clock);
    end
    check({tag, " no_retx"}, late_busy, 0);
  endtask

  task automatic send_rx(input logic [7:0] d, input logic stop_bit);
    logic [9:0] fr;
    fr = {stop_bit, d, 1'b0};
    for (int b = 0; b < FRAME_BITS; b++) begin
      ser_rx = fr[b];
      repeat (CPB) @(negedge clock);
    end
    ser_rx = 1'b1;
  endtask

  initial begin
    int base;
    int err_base;
    resetb   = 1'b0;
    ser_rx   = 1'b1;
    tx_start = 1'b0;
    tx_data  = 8'h00;
    repeat (3) @(negedge clock);
    check("rst ser_tx", ser_tx, 1);
    check("rst tx_busy", tx_busy, 0);
    check("rst tx_clear_req", tx_clear_req, 0);
    check("rst rx_valid", rx_valid, 0);
    check("rst rx_data", rx_data, 0);
    check("rst rx_frame_err", rx_frame_err, 0);
    resetb = 1'b1;
    repeat (2) @(negedge clock);

    // 0x3D, tx_start held high through and after the frame
    tx_data  = 8'h3D;
    tx_start = 1'b1;
    tx_frame(10'b1001111010, 1'b0, "tx3d");

    // 0x0F, with an extra rising edge of tx_start mid-frame
    tx_start = 1'b0;
    @(negedge clock);
    tx_data  = 8'h0F;
    tx_start = 1'b1;
    tx_frame(10'b1000011110, 1'b1, "tx0f");
    tx_start = 1'b0;
    @(negedge clock);

    // single RX frame
    base = rx_q.size();
    err_base = err_cnt;
    send_rx(8'hAB, 1'b1);
    repeat (2 * CPB) @(negedge clock);
    check("rx_ab count", rx_q.size() - base, 1);
    if (rx_q.size() > base) check("rx_ab value", rx_q[base], 8'hAB);
    check("rx_ab rx_data", rx_data, 8'hAB);
    check("rx_ab no_err", err_cnt - err_base, 0);

    // back-to-back frames, no idle gap
    base = rx_q.size();
    send_rx(8'h40, 1'b1);
    send_rx(8'h61, 1'b1);
    repeat (2 * CPB) @(negedge clock);
    check("rx_b2b count", rx_q.size() - base, 2);
    if (rx_q.size() > base + 1) begin
      check("rx_b2b first", rx_q[base], 8'h40);
      check("rx_b2b second", rx_q[base+1], 8'h61);
    end

    // short low glitch
    base = rx_q.size();
    err_base = err_cnt;
    ser_rx = 1'b0;
    repeat (2) @(negedge clock);
    ser_rx = 1'b1;
    repeat (3 * CPB) @(negedge clock);
    check("glitch no_valid", rx_q.size() - base, 0);
    check("glitch no_err", err_cnt - err_base, 0);

    // stop bit sampled low
    base = rx_q.size();
    err_base = err_cnt;
    send_rx(8'h55, 1'b0);
    repeat (2 * CPB) @(negedge clock);
    check("ferr pulse", err_cnt - err_base, 1);
    check("ferr no_valid", rx_q.size() - base, 0);
    check("ferr rx_data kept", rx_data, 8'h61);

    // full duplex
    base = rx_q.size();
    tx_data  = 8'h3D;
    tx_start = 1'b1;
    fork
      tx_frame(10'b1001111010, 1'b0, "fdx_tx");
      send_rx(8'h3D, 1'b1);
    join
    repeat (CPB) @(negedge clock);
    check("fdx rx count", rx_q.size() - base, 1);
    check("fdx rx_data", rx_data, 8'h3D);

    // asynchronous reset in the middle of a start bit
    tx_start = 1'b0;
    @(negedge clock);
    tx_data  = 8'hA5;
    tx_start = 1'b1;
    repeat (2) @(negedge clock);
    check("mid ser_tx low", ser_tx, 0);
    check("mid busy", tx_busy, 1);
    #2 resetb = 1'b0;
    #1;
    check("arst ser_tx", ser_tx, 1);
    check("arst tx_busy", tx_busy, 0);
    check("arst rx_data", rx_data, 0);
    @(negedge clock);
    tx_start = 1'b0;
    resetb   = 1'b1;
    repeat (2) @(negedge clock);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/uart_tb_txrx.md
Name: uart_tb_txrx

Overview:
- Bench-side UART transceiver, 8N1 framing, LSB first, no parity.
- It connects to the SoC user GPIO pins: ser_rx is driven by the chip's uart_tx pad (mprj_io[6]), and ser_tx drives the chip's uart_rx pad (mprj_io[5]).
- The bench loads one byte and pulses tx_start; the block serialises the byte to the chip.
- Bytes the chip transmits are deserialised and presented on rx_data / rx_valid.
- Fully synchronous to one clock; synthesizable.

Parameters:
- CLKS_PER_BIT, default 4167: clock cycles per bit (40 MHz / 9600 baud). Legal range is 4 or more.
- DATA_BITS, default 8: payload bits per frame. Fixed at 8 for this block.

Ports:
- clock  in  1  system clock, 25 ns period in the SoC bench.
- resetb  in  1  asynchronous, active-low reset.
- ser_rx  in  1  serial input from the chip; idle level is 1.
- ser_tx  out  1  serial output to the chip; idle level is 1.
- tx_start  in  1  transmit request; acts on its rising edge only.
- tx_data  in  8  byte to transmit; sampled on the launch cycle.
- tx_busy  out  1  high while a transmit frame is in progress.
- tx_clear_req  out  1  one-cycle pulse when the stop bit completes; tells the bench it may drop tx_start.
- rx_data  out  8  last received byte.
- rx_valid  out  1  one-cycle pulse when rx_data updates.
- rx_frame_err  out  1  one-cycle pulse when a received stop bit samples as 0.

Behaviour:
- Reset (asynchronous, while resetb=0):
  - ser_tx=1, tx_busy=0, tx_clear_req=0.
  - rx_data=0, rx_valid=0, rx_frame_err=0.
  - Both FSMs go to IDLE; all counters are cleared; the tx_start edge register is cleared to 0.
- TX launch:
  - Register tx_start_q <= tx_start each cycle.
  - Launch when tx_start=1, tx_start_q=0 and the TX FSM is in IDLE. On that clock edge, latch tx_data into the shift register.
  - tx_busy=1 from the edge after the launch edge. Latency from tx_start high to tx_busy high is at most 1 clock, so tx_busy is always high within 50 ns.
  - A rising edge of tx_start while busy is ignored (no queueing).
  - Holding tx_start high after a frame never retransmits.
- TX FSM, states IDLE -> START -> DATA -> STOP -> IDLE:
  - START drives 0 for CLKS_PER_BIT cycles.
  - DATA drives bits 0..7, LSB first, each for CLKS_PER_BIT cycles.
  - STOP drives 1 for CLKS_PER_BIT cycles.
  - Total frame length is 10*CLKS_PER_BIT cycles.
  - On the last STOP cycle: tx_busy falls to 0 and tx_clear_req pulses for 1 cycle (same edge).
  - A new launch is accepted in the cycle after returning to IDLE.
- RX synchroniser: ser_rx passes through a 2-flop synchroniser whose flops reset to 1. All RX decisions use the synchronised signal.
- RX FSM, states IDLE -> START -> DATA -> STOP -> IDLE:
  - IDLE: a falling edge (synchronised value 0) enters START.
  - START: at CLKS_PER_BIT/2 re-check the line. If it is 1, treat it as a glitch and return to IDLE. If it is 0, continue.
  - DATA: sample at mid-bit, every CLKS_PER_BIT cycles, 8 times, shifting LSB first.
  - STOP: sample at mid-stop-bit.
    - If 1: rx_data <= assembled byte and rx_valid pulses for 1 cycle.
    - If 0: rx_data is unchanged and rx_frame_err pulses for 1 cycle.
    - Then return to IDLE. Back-to-back frames are accepted with zero idle gap.
- TX and RX are independent; simultaneous full-duplex operation is required.
- Counters are sized to $clog2(CLKS_PER_BIT)+1 bits, and the bit index is 3 bits. No wrap-around beyond the terminal count; each counter clears on every state change.

Decomposition:
- Shared package uart_pkg:
  - typedef uart_state_e {IDLE, START, DATA, STOP}.
  - Constant FRAME_BITS=10.
- One natural sub-module, uart_bit_timer: a cycle counter with a restart input and half-bit and full-bit pulse outputs. It is instantiated once per direction.

Test Plan:
- Reset: hold resetb=0 with ser_rx=1 -> ser_tx=1, tx_busy=0, rx_valid=0. Assert resetb=0 mid-frame -> ser_tx=1 and tx_busy=0 immediately, without waiting for a clock edge.
- TX byte 61 (0x3D): raise tx_start with tx_data=61 and hold it high until tx_busy=0.
  - tx_busy=1 within 2 clocks.
  - ser_tx sequence is 0,1,0,1,1,1,1,0,0,1, each bit exactly CLKS_PER_BIT cycles.
  - tx_clear_req pulses once; no second frame follows while tx_start stays high.
- TX byte 15 (0x0F) right after 61: toggle tx_start low then high -> ser_tx sequence 0,1,1,1,1,0,0,0,0,1. A rising edge during the busy period is ignored.
- RX: drive ser_rx with the frame for 0xAB at CLKS_PER_BIT -> rx_valid pulses once with rx_data=0xAB. Back-to-back 0x40 then 0x61 -> two pulses, with values 0x40 then 0x61.
- RX glitch and error:
  - A low pulse on ser_rx shorter than CLKS_PER_BIT/2 -> no rx_valid.
  - A frame with stop bit 0 -> rx_frame_err pulse, and rx_data keeps its previous value.
- Full duplex: transmit 61 while receiving 0x3D at the same time -> both complete correctly and rx_data=0x3D.
